// File: rtl/morse_pkg.sv
// Shared constants for the Morse symbol assembler: event codes, assembler state encoding
// and the token field layout {bits, len, space, err}.
package morse_pkg;

  localparam int MAX_ELEMENTS_DEF = 6;
  localparam int FIFO_DEPTH_DEF   = 4;

  localparam logic [2:0] EV_NOTHING      = 3'd0;
  localparam logic [2:0] EV_DIT          = 3'd1;
  localparam logic [2:0] EV_DASH         = 3'd2;
  localparam logic [2:0] EV_LETTER_SPACE = 3'd3;
  localparam logic [2:0] EV_WORD_SPACE   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ERROR   = 2'd2
  } state_t;

  // Packed token: bits in the MSBs, then len, then the space and err flags.
  function automatic int tok_width(input int max_el);
    return max_el + $clog2(max_el + 1) + 2;
  endfunction

endpackage

// File: rtl/morse_symbol_assembler_if.sv
// Token handshake between the symbol assembler (master) and the character decoder (slave).
interface morse_symbol_assembler_if #(
  parameter int MAX_ELEMENTS = 6
);
  localparam int LEN_W = $clog2(MAX_ELEMENTS + 1);

  // A token moves on a clock edge where sym_valid && sym_ready; while sym_valid is high and
  // sym_ready low the master holds every payload field stable.
  logic                    sym_valid;
  logic                    sym_ready;
  logic [MAX_ELEMENTS-1:0] sym_bits;
  logic [LEN_W-1:0]        sym_len;
  logic                    sym_space;
  logic                    sym_err;

  modport master (
    output sym_valid, sym_bits, sym_len, sym_space, sym_err,
    input  sym_ready
  );

  modport slave (
    input  sym_valid, sym_bits, sym_len, sym_space, sym_err,
    output sym_ready
  );

endinterface

// File: rtl/morse_token_fifo.sv
// Generic valid/ready FIFO with wrap-around pointers and an occupancy count; a push into a
// full FIFO is accepted when a pop happens on the same edge.
module morse_token_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occ;
  logic             do_push;
  logic             do_pop;

  assign out_valid = (occ != '0);
  assign in_ready  = (occ != CNT_W'(DEPTH)) || out_ready;
  assign do_pop    = out_valid && out_ready;
  assign do_push   = in_valid && in_ready;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      occ <= occ + CNT_W'(1);
      else if (do_pop && !do_push) occ <= occ - CNT_W'(1);
    end
  end

endmodule

// File: rtl/morse_symbol_assembler.sv
// Assembles dit/dash/space events into character tokens. Define MORSE_TOKEN_FIFO_EN for a
// FIFO_DEPTH-entry output FIFO; otherwise the output stage is a single holding register.
module morse_symbol_assembler
  import morse_pkg::*;
#(
  parameter int MAX_ELEMENTS = MAX_ELEMENTS_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                     clock_1khz,
  input  logic                     rst,
  input  logic [2:0]               pulse_event,
  input  logic                     enable,
  morse_symbol_assembler_if.master sym,
  output logic                     overrun,
  output logic                     busy,
  output state_t                   dbg_state
);
  localparam int LEN_W = $clog2(MAX_ELEMENTS + 1);
  localparam int TOK_W = MAX_ELEMENTS + LEN_W + 2;

  state_t                  state;
  logic [LEN_W-1:0]        count;
  logic [MAX_ELEMENTS-1:0] shift;
  logic                    pending_space;

  logic             is_elem, is_dash, is_term, is_word;
  logic             done, set_pending;
  logic [TOK_W-1:0] done_tok;
  logic [TOK_W-1:0] push_tok;
  logic             room, push, push_space, drop;

  assign is_dash = (pulse_event == EV_DASH);
  assign is_elem = enable && ((pulse_event == EV_DIT) || is_dash);
  assign is_word = enable && (pulse_event == EV_WORD_SPACE);
  assign is_term = is_word || (enable && (pulse_event == EV_LETTER_SPACE));

  always_comb begin
    done        = 1'b0;
    set_pending = 1'b0;
    done_tok    = '0;
    case (state)
      ST_IDLE: if (is_word) begin
        done     = 1'b1;
        done_tok = TOK_W'(2'b10);
      end
      ST_COLLECT: if (is_term) begin
        done        = 1'b1;
        set_pending = is_word;
        done_tok    = {shift, count, 2'b00};
      end
      ST_ERROR: if (is_term) begin
        done        = 1'b1;
        set_pending = is_word;
        done_tok    = TOK_W'(2'b01);
      end
      default: ;
    endcase
  end

  // A waiting word space wins the output stage; any completion on that edge is dropped.
  assign push_space = pending_space && room;
  assign push       = push_space || (done && room && !pending_space);
  assign drop       = done && !(room && !pending_space);
  assign push_tok   = push_space ? TOK_W'(2'b10) : done_tok;

  assign busy      = (state != ST_IDLE) || pending_space;
  assign dbg_state = state;

  always_ff @(posedge clock_1khz or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      count         <= '0;
      shift         <= '0;
      pending_space <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= drop;
      if (set_pending)     pending_space <= 1'b1;
      else if (push_space) pending_space <= 1'b0;
      case (state)
        ST_IDLE: if (is_elem) begin
          shift <= MAX_ELEMENTS'(is_dash);
          count <= LEN_W'(1);
          state <= ST_COLLECT;
        end
        ST_COLLECT: begin
          if (is_elem) begin
            if (count == LEN_W'(MAX_ELEMENTS)) begin
              state <= ST_ERROR;
            end else begin
              shift[count] <= is_dash;
              count        <= count + LEN_W'(1);
            end
          end else if (is_term) begin
            shift <= '0;
            count <= '0;
            state <= ST_IDLE;
          end
        end
        ST_ERROR: if (is_term) begin
          shift <= '0;
          count <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MORSE_TOKEN_FIFO_EN
  logic [TOK_W-1:0] out_tok;

  morse_token_fifo #(
    .WIDTH (TOK_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clock_1khz),
    .rst       (rst),
    .in_valid  (push),
    .in_ready  (room),
    .in_data   (push_tok),
    .out_valid (sym.sym_valid),
    .out_ready (sym.sym_ready),
    .out_data  (out_tok)
  );

  assign {sym.sym_bits, sym.sym_len, sym.sym_space, sym.sym_err} = out_tok;
`else
  // A pop on the same edge frees the holding register for the incoming token.
  assign room = !sym.sym_valid || sym.sym_ready;

  always_ff @(posedge clock_1khz or posedge rst) begin
    if (rst) begin
      sym.sym_valid <= 1'b0;
      sym.sym_bits  <= '0;
      sym.sym_len   <= '0;
      sym.sym_space <= 1'b0;
      sym.sym_err   <= 1'b0;
    end else if (push) begin
      sym.sym_valid <= 1'b1;
      {sym.sym_bits, sym.sym_len, sym.sym_space, sym.sym_err} <= push_tok;
    end else if (sym.sym_ready) begin
      sym.sym_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_morse_symbol_assembler.sv
// Self-checking bench for morse_symbol_assembler; token expectations go through a queue that
// a negedge monitor compares against every accepted token. Honors MORSE_TOKEN_FIFO_EN.
module tb_morse_symbol_assembler;
  import morse_pkg::*;

  localparam int MAX_EL = 6;
  localparam int LEN_W  = 3;
  localparam int TOK_W  = MAX_EL + LEN_W + 2;
`ifdef MORSE_TOKEN_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clock_1khz = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] pulse_event = EV_NOTHING;
  logic       enable = 1'b1;
  logic       overrun;
  logic       busy;
  state_t     dbg_state;

  morse_symbol_assembler_if #(.MAX_ELEMENTS(MAX_EL)) sym_if ();

  morse_symbol_assembler #(
    .MAX_ELEMENTS (MAX_EL),
    .FIFO_DEPTH   (4)
  ) dut (
    .clock_1khz  (clock_1khz),
    .rst         (rst),
    .pulse_event (pulse_event),
    .enable      (enable),
    .sym         (sym_if),
    .overrun     (overrun),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  always #5 clock_1khz = ~clock_1khz;

  logic [TOK_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int ovr_cycles = 0;

  function automatic logic [TOK_W-1:0] tok(input logic [MAX_EL-1:0] bits, input int len,
                                           input logic space, input logic err);
    return {bits, LEN_W'(len), space, err};
  endfunction

  // Monitor: compare each accepted token with the head of the expected queue.
  always @(negedge clock_1khz) begin
    logic [TOK_W-1:0] act, exp;
    if (overrun) ovr_cycles++;
    if (!rst && sym_if.sym_valid && sym_if.sym_ready) begin
      act = {sym_if.sym_bits, sym_if.sym_len, sym_if.sym_space, sym_if.sym_err};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_token: got %h, required no token", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL token: got %h, required %h", act, exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock_1khz);
    #1;
  endtask

  task automatic send_event(input logic [2:0] ev);
    pulse_event = ev;
    step();
    pulse_event = EV_NOTHING;
  endtask

  task automatic send_letter(input logic [MAX_EL-1:0] bits, input int len, input logic [2:0] term);
    for (int i = 0; i < len; i++) send_event(bits[i] ? EV_DASH : EV_DIT);
    send_event(term);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((exp_q.size() != 0 || sym_if.sym_valid) && k < 100) begin
      step();
      k++;
    end
    checks++;
    if (k >= 100) begin
      errors++;
      $display("FAIL drain_timeout: %0d tokens outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({sym_if.sym_valid, sym_if.sym_bits, sym_if.sym_len, sym_if.sym_space, sym_if.sym_err,
         overrun, busy} !== '0) begin
      errors++;
      $display("FAIL %s: valid=%b bits=%b len=%0d space=%b err=%b overrun=%b busy=%b, required all 0",
               name, sym_if.sym_valid, sym_if.sym_bits, sym_if.sym_len, sym_if.sym_space,
               sym_if.sym_err, overrun, busy);
    end
  endtask

  task automatic test_reset();
    sym_if.sym_ready = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check_idle_outputs("reset_outputs");
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_letter();
    sym_if.sym_ready = 1'b1;
    send_event(EV_DIT);
    send_event(3'd5);
    send_event(EV_DASH);
    send_event(3'd6);
    send_event(3'd7);
    check_bit("no_token_before_space", sym_if.sym_valid, 1'b0);
    exp_q.push_back(tok(6'b000010, 2, 1'b0, 1'b0));
    send_event(EV_LETTER_SPACE);
    @(negedge clock_1khz);
    check_bit("latency_one_cycle", sym_if.sym_valid, 1'b1);
    step();
    wait_drain();
  endtask

  task automatic test_overflow();
    int ovr0 = ovr_cycles;
    sym_if.sym_ready = 1'b1;
    exp_q.push_back(tok(6'b0, 0, 1'b0, 1'b1));
    send_letter(7'b0, 7, EV_LETTER_SPACE);
    wait_drain();
    checks++;
    if (ovr_cycles != ovr0) begin
      errors++;
      $display("FAIL overflow_no_overrun: got %0d overrun cycles, required 0", ovr_cycles - ovr0);
    end
  endtask

  task automatic test_word_space();
    sym_if.sym_ready = 1'b1;
    exp_q.push_back(tok(6'b000001, 1, 1'b0, 1'b0));
    exp_q.push_back(tok(6'b0, 0, 1'b1, 1'b0));
    send_letter(6'b000001, 1, EV_WORD_SPACE);
    @(negedge clock_1khz);
    check_bit("word_letter_valid", sym_if.sym_valid && (sym_if.sym_len == 3'd1), 1'b1);
    check_bit("word_pending_busy", busy, 1'b1);
    @(negedge clock_1khz);
    check_bit("word_space_next_cycle", sym_if.sym_valid && sym_if.sym_space, 1'b1);
    check_bit("word_busy_cleared", busy, 1'b0);
    step();
    wait_drain();
  endtask

  task automatic test_backpressure();
    int ovr0 = ovr_cycles;
    sym_if.sym_ready = 1'b0;
    for (int n = 0; n <= CAP; n++) begin
      if (n < CAP) exp_q.push_back(tok(MAX_EL'(n + 1) & 6'b000011, 2, 1'b0, 1'b0));
      send_letter(MAX_EL'(n + 1), 2, EV_LETTER_SPACE);
    end
    repeat (3) step();
    checks++;
    if (ovr_cycles - ovr0 != 1) begin
      errors++;
      $display("FAIL backpressure_overrun: got %0d overrun cycles, required 1", ovr_cycles - ovr0);
    end
    check_bit("backpressure_held", sym_if.sym_valid, 1'b1);
    sym_if.sym_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_pending_priority();
    int ovr0 = ovr_cycles;
    sym_if.sym_ready = 1'b0;
    for (int n = 0; n < CAP - 1; n++) begin
      exp_q.push_back(tok(MAX_EL'(n & 1), 1, 1'b0, 1'b0));
      send_letter(MAX_EL'(n & 1), 1, EV_LETTER_SPACE);
    end
    exp_q.push_back(tok(6'b000001, 1, 1'b0, 1'b0));
    exp_q.push_back(tok(6'b0, 0, 1'b1, 1'b0));
    send_letter(6'b000001, 1, EV_WORD_SPACE);
    send_event(EV_DIT);
    check_bit("pending_busy", busy, 1'b1);
    sym_if.sym_ready = 1'b1;
    send_event(EV_LETTER_SPACE);
    wait_drain();
    checks++;
    if (ovr_cycles - ovr0 != 1) begin
      errors++;
      $display("FAIL pending_priority_overrun: got %0d overrun cycles, required 1", ovr_cycles - ovr0);
    end
    check_bit("pending_busy_cleared", busy, 1'b0);
  endtask

  task automatic test_enable();
    sym_if.sym_ready = 1'b1;
    send_event(EV_DIT);
    enable = 1'b0;
    send_event(EV_DASH);
    send_event(EV_LETTER_SPACE);
    send_event(EV_WORD_SPACE);
    check_bit("disabled_busy_held", busy, 1'b1);
    check_bit("disabled_no_token", sym_if.sym_valid, 1'b0);
    enable = 1'b1;
    exp_q.push_back(tok(6'b000010, 2, 1'b0, 1'b0));
    send_event(EV_DASH);
    send_event(EV_LETTER_SPACE);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    sym_if.sym_ready = 1'b0;
    send_letter(6'b000000, 1, EV_LETTER_SPACE);
    send_event(EV_DIT);
    send_event(EV_DASH);
    check_bit("pre_reset_valid", sym_if.sym_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("reset_mid_outputs");
    step();
    rst = 1'b0;
    sym_if.sym_ready = 1'b1;
    exp_q.push_back(tok(6'b000000, 1, 1'b0, 1'b0));
    send_letter(6'b000000, 1, EV_LETTER_SPACE);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int len;
    logic [MAX_EL-1:0] bits;
    sym_if.sym_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      len  = $urandom_range(1, MAX_EL);
      bits = MAX_EL'($urandom_range(0, 63));
      bits = bits & MAX_EL'((1 << len) - 1);
      exp_q.push_back(tok(bits, len, 1'b0, 1'b0));
      send_letter(bits, len, ($urandom_range(0, 1) == 1) ? EV_LETTER_SPACE : 3'd3);
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_letter();
    test_overflow();
    test_word_space();
    test_backpressure();
    test_pending_priority();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
